stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 1000000, giving the debounce stability window in clk cycles (10 ms at 100 MHz); legal range is 2 or more.
REQ-002 The block SHALL have port clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port btn_go, input, 1 bit: raw start/stop pushbutton, asynchronous, bouncing, active-high.
REQ-005 The block SHALL have port btn_clr, input, 1 bit: raw clear pushbutton, asynchronous, bouncing, active-high.
REQ-006 The block SHALL have port en, output, 1 bit: count enable to the downstream centisecond counter; high only in RUN.
REQ-007 The block SHALL have port clr, output, 1 bit: registered one-cycle clear pulse to the downstream counter's reset.
REQ-008 The block SHALL have port state, output, 2 bits: current state, encoded IDLE=00, RUN=01, PAUSED=10; 11 is never driven.

Function
REQ-009 Each button SHALL pass through a 2-flop synchronizer (sync1 then sync2) before any other logic.
REQ-010 Each button SHALL have a debounced level db and a stability counter of $clog2(DB_CYCLES) bits.
REQ-011 When sync2 == db, the stability counter SHALL be cleared to 0 on the clock edge.
REQ-012 When sync2 != db and counter == DB_CYCLES-1, the block SHALL set db <= sync2 and counter <= 0.
REQ-013 When sync2 != db and counter < DB_CYCLES-1, the counter SHALL increment by 1 with no wrap.
REQ-014 A bounce shorter than DB_CYCLES consecutive cycles SHALL never change db.
REQ-015 A press pulse (go_p, clr_p) SHALL be a register set high for exactly one cycle on the edge where db goes 0->1; a db 1->0 transition produces no pulse.
REQ-016 A raw level held stable from sampling edge 1 SHALL produce a press pulse high after edge DB_CYCLES+2, and the state/en/clr update after edge DB_CYCLES+3.
REQ-017 On go_p, the FSM SHALL transition IDLE->RUN, RUN->PAUSED, PAUSED->RUN.
REQ-018 On clr_p, the FSM SHALL transition IDLE->IDLE and PAUSED->IDLE, asserting clr for that one cycle; in RUN, clr_p is ignored.
REQ-019 On simultaneous go_p and clr_p, clr_p SHALL take priority in IDLE/PAUSED (go to IDLE, pulse clr); go_p SHALL take priority in RUN (go to PAUSED, no clr).
REQ-020 en SHALL be a registered output equal to (next state == RUN), so it changes on the same edge as state.
REQ-021 clr SHALL be high for exactly one cycle per accepted clear, with no glitches, and never while en = 1.
REQ-022 A button held continuously SHALL produce exactly one press pulse; a second action requires a release of at least DB_CYCLES+2 cycles followed by a new press.

Reset
REQ-023 While rst = 1 at a clock edge, the block SHALL clear sync1, sync2, db, the stability counters and the pulse registers to 0, set state to IDLE (00), and set en = 0 and clr = 0.
REQ-024 rst asserted mid-operation (any state, mid-debounce) SHALL take effect at the next edge; partial debounce progress is discarded.
REQ-025 clr SHALL NOT pulse as a result of reset.
REQ-026 A button held high through reset release SHALL be treated as a new press and produce one pulse DB_CYCLES+2 edges after release.

Verification (DB_CYCLES=4)
REQ-027 Directed test: after reset, hold btn_go=1 from edge 1 -> go_p high after edge 6; state=01 and en=1 after edge 7; clr stays 0.
REQ-028 Directed test: in RUN, toggle btn_go 1,0,1 every 2 cycles, then settle to 0 -> no state change; en stays 1.
REQ-029 Directed test: RUN, then a clean go press -> PAUSED (10) with en=0; then a clean clr press -> clr=1 for exactly 1 cycle, state=00.
REQ-030 Directed test: in RUN, press btn_clr alone -> no clr pulse, state stays 01; in RUN, press btn_go and btn_clr on the same edge -> PAUSED, clr=0.
REQ-031 Directed test: in PAUSED, press btn_go and btn_clr together -> IDLE with a 1-cycle clr; assert rst for 1 cycle mid-debounce of a go press -> state=00, en=0, clr=0, no pulse from the interrupted press.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-panel controller: synchronizes and debounces the go/clear
// pushbuttons and sequences IDLE/RUN/PAUSED, driving the counter enable and clear.
module stopwatch_ctrl #(
   parameter int DB_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_go,
   input  logic       btn_clr,
   output logic       en,
   output logic       clr,
   output logic [1:0] state
);
   // state  | meaning
   // IDLE   | stopped and cleared, counter held
   // RUN    | counting, en high
   // PAUSED | stopped, count retained until clear or restart

   localparam int CW = $clog2(DB_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RUN    = 2'b01,
      PAUSED = 2'b10
   } state_t;

   // Bit 0 carries the go button, bit 1 the clear button.
   logic [1:0]    btn_raw;
   logic [1:0]    sync1_q;
   logic [1:0]    sync2_q;
   logic [1:0]    db_q;
   logic [1:0]    db_d;
   logic [1:0]    pulse_q;
   logic [1:0]    pulse_d;
   logic [CW-1:0] cnt_q [2];
   logic [CW-1:0] cnt_d [2];

   state_t st_q;
   logic   en_q;
   logic   clr_q;
   logic   go_p;
   logic   clr_p;

   assign btn_raw = {btn_clr, btn_go};

   // The counter only advances while the synchronized level disagrees with
   // the debounced level, so any agreement restarts the stability window.
   always_comb begin
      db_d    = db_q;
      pulse_d = 2'b00;
      cnt_d   = '{default: '0};
      for (int i = 0; i < 2; i++) begin
         if (sync2_q[i] != db_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               db_d[i]    = sync2_q[i];
               pulse_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 2'b00;
         sync2_q <= 2'b00;
         db_q    <= 2'b00;
         pulse_q <= 2'b00;
         cnt_q   <= '{default: '0};
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         db_q    <= db_d;
         pulse_q <= pulse_d;
         cnt_q   <= cnt_d;
      end
   end

   assign go_p  = pulse_q[0];
   assign clr_p = pulse_q[1];

   // Clear wins in IDLE/PAUSED; in RUN a clear is ignored so clr never
   // coincides with en.
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q  <= IDLE;
         en_q  <= 1'b0;
         clr_q <= 1'b0;
      end else begin
         clr_q <= 1'b0;
         case (st_q)
            IDLE: begin
               if (clr_p) begin
                  clr_q <= 1'b1;
                  en_q  <= 1'b0;
               end else if (go_p) begin
                  st_q <= RUN;
                  en_q <= 1'b1;
               end
            end
            RUN: begin
               if (go_p) begin
                  st_q <= PAUSED;
                  en_q <= 1'b0;
               end
            end
            PAUSED: begin
               if (clr_p) begin
                  st_q  <= IDLE;
                  en_q  <= 1'b0;
                  clr_q <= 1'b1;
               end else if (go_p) begin
                  st_q <= RUN;
                  en_q <= 1'b1;
               end
            end
            default: begin
               st_q <= IDLE;
               en_q <= 1'b0;
            end
         endcase
      end
   end

   assign en    = en_q;
   assign clr   = clr_q;
   assign state = st_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus randomized button traffic
// checked every cycle against a window-based reference model.
module tb_stopwatch_ctrl;
   localparam int DB   = 4;
   localparam int MAXE = 8192;
   localparam logic [1:0] S_IDLE   = 2'b00;
   localparam logic [1:0] S_RUN    = 2'b01;
   localparam logic [1:0] S_PAUSED = 2'b10;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_go = 1'b0;
   logic       btn_clr = 1'b0;
   logic       en;
   logic       clr;
   logic [1:0] state;

   int tests_run = 0;
   int fails     = 0;
   int mdl_diff  = 0;
   int overlap   = 0;
   int clr_seen  = 0;

   stopwatch_ctrl #(.DB_CYCLES(DB)) dut (
      .clk    (clk),
      .rst    (rst),
      .btn_go (btn_go),
      .btn_clr(btn_clr),
      .en     (en),
      .clr    (clr),
      .state  (state)
   );

   always #5 clk = ~clk;

   // Reference model: a debounced level flips at edge n when the raw level
   // sampled two edges earlier differed from it on each of the last DB edges,
   // with no reset touching the window or the synchronizer path.
   bit         rst_h [MAXE];
   bit         raw_h [2][MAXE];
   int         n = 0;
   bit         m_db [2];
   bit         m_p [2];
   bit         np [2];
   bit         flip;
   bit         v;
   int         k;
   logic [1:0] m_state = 2'b00;
   logic       m_en = 1'b0;
   logic       m_clr = 1'b0;

   always @(posedge clk) begin
      n = n + 1;
      rst_h[n]    = rst;
      raw_h[0][n] = btn_go;
      raw_h[1][n] = btn_clr;
      if (rst) begin
         m_db = '{0, 0};
         m_p = '{0, 0};
         m_state = S_IDLE;
         m_en = 1'b0;
         m_clr = 1'b0;
      end else begin
         m_clr = 1'b0;
         if (m_state == S_RUN) begin
            if (m_p[0]) m_state = S_PAUSED;
         end else if (m_p[1]) begin
            m_state = S_IDLE;
            m_clr = 1'b1;
         end else if (m_p[0]) begin
            m_state = S_RUN;
         end
         m_en = (m_state == S_RUN);
         for (int b = 0; b < 2; b++) begin
            flip = 1'b1;
            for (int j = 0; j < DB; j++) begin
               k = n - j;
               if (k < 3 || rst_h[k]) flip = 1'b0;
               else begin
                  v = (rst_h[k-1] || rst_h[k-2]) ? 1'b0 : raw_h[b][k-2];
                  if (v == m_db[b]) flip = 1'b0;
               end
            end
            np[b] = flip && !m_db[b];
            if (flip) m_db[b] = !m_db[b];
         end
         m_p = np;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if ({state, en, clr} !== {m_state, m_en, m_clr}) mdl_diff++;
      if (clr && en) overlap++;
      if (clr) clr_seen++;
   endtask

   task automatic press(input bit g, input bit c);
      btn_go = g;
      btn_clr = c;
      repeat (DB + 6) tick();
      btn_go = 1'b0;
      btn_clr = 1'b0;
      repeat (DB + 6) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      btn_go = 1'b0;
      btn_clr = 1'b0;
      tick();
      tick();
      tests_run++;
      if ({state, en, clr} !== 4'b0000) begin
         fails++;
         $display("FAIL reset: state=%b en=%b clr=%b, expected 00 0 0", state, en, clr);
      end
      mdl_diff = 0;
   endtask

   task automatic test_go_start();
      logic exp;
      rst = 1'b0;
      btn_go = 1'b1;
      for (int e = 1; e <= 9; e++) begin
         tick();
         exp = (e >= DB + 3);
         tests_run++;
         if ({state, en, clr} !== {1'b0, exp, exp, 1'b0}) begin
            fails++;
            $display("FAIL go_start edge %0d: state=%b en=%b clr=%b, expected state=0%b en=%b clr=0",
                     e, state, en, clr, exp, exp);
         end
      end
      btn_go = 1'b0;
      repeat (DB + 4) tick();
      tests_run++;
      if (state !== S_RUN || mdl_diff !== 0) begin
         fails++;
         $display("FAIL go_release: state=%b model_diffs=%0d, expected 01 and 0", state, mdl_diff);
      end
   endtask

   task automatic test_bounce();
      bit pat [7] = '{1, 1, 0, 0, 1, 1, 0};
      for (int i = 0; i < 15; i++) begin
         btn_go = (i < 7) ? pat[i] : 1'b0;
         tick();
         tests_run++;
         if (state !== S_RUN || en !== 1'b1) begin
            fails++;
            $display("FAIL bounce cycle %0d: state=%b en=%b, expected 01 1", i, state, en);
         end
      end
   endtask

   task automatic test_pause_clear();
      press(1'b1, 1'b0);
      tests_run++;
      if (state !== S_PAUSED || en !== 1'b0) begin
         fails++;
         $display("FAIL pause: state=%b en=%b, expected 10 0", state, en);
      end
      clr_seen = 0;
      press(1'b0, 1'b1);
      tests_run++;
      if (clr_seen !== 1 || state !== S_IDLE) begin
         fails++;
         $display("FAIL clear_paused: clr cycles=%0d state=%b, expected 1 and 00", clr_seen, state);
      end
   endtask

   task automatic test_run_clr();
      press(1'b1, 1'b0);
      clr_seen = 0;
      press(1'b0, 1'b1);
      tests_run++;
      if (state !== S_RUN || clr_seen !== 0) begin
         fails++;
         $display("FAIL clr_in_run: state=%b clr cycles=%0d, expected 01 and 0", state, clr_seen);
      end
      press(1'b1, 1'b1);
      tests_run++;
      if (state !== S_PAUSED || clr_seen !== 0) begin
         fails++;
         $display("FAIL both_in_run: state=%b clr cycles=%0d, expected 10 and 0", state, clr_seen);
      end
   endtask

   task automatic test_paused_both();
      clr_seen = 0;
      press(1'b1, 1'b1);
      tests_run++;
      if (state !== S_IDLE || en !== 1'b0 || clr_seen !== 1) begin
         fails++;
         $display("FAIL both_in_paused: state=%b en=%b clr cycles=%0d, expected 00 0 1",
                  state, en, clr_seen);
      end
   endtask

   task automatic test_hold();
      btn_go = 1'b1;
      repeat (40) tick();
      btn_go = 1'b0;
      repeat (DB + 6) tick();
      tests_run++;
      if (state !== S_RUN) begin
         fails++;
         $display("FAIL held_button: state=%b, expected 01 (single action)", state);
      end
   endtask

   task automatic test_rst_mid();
      btn_go = 1'b1;
      repeat (3) tick();
      rst = 1'b1;
      btn_go = 1'b0;
      clr_seen = 0;
      tick();
      tests_run++;
      if ({state, en, clr} !== 4'b0000) begin
         fails++;
         $display("FAIL rst_mid: state=%b en=%b clr=%b, expected 00 0 0", state, en, clr);
      end
      rst = 1'b0;
      repeat (DB + 8) tick();
      tests_run++;
      if (state !== S_IDLE || clr_seen !== 0) begin
         fails++;
         $display("FAIL rst_interrupted_press: state=%b clr cycles=%0d, expected 00 and 0",
                  state, clr_seen);
      end
   endtask

   task automatic test_hold_through_reset();
      logic exp;
      rst = 1'b1;
      btn_go = 1'b1;
      tick();
      rst = 1'b0;
      for (int e = 1; e <= 9; e++) begin
         tick();
         exp = (e >= DB + 3);
         tests_run++;
         if (state !== {1'b0, exp}) begin
            fails++;
            $display("FAIL hold_through_reset edge %0d: state=%b, expected 0%b", e, state, exp);
         end
      end
      btn_go = 1'b0;
      repeat (DB + 6) tick();
      tests_run++;
      if (mdl_diff !== 0) begin
         fails++;
         $display("FAIL directed_vs_model: %0d cycles differ, expected 0", mdl_diff);
      end
   endtask

   task automatic test_random();
      int len;
      for (int s = 0; s < 300; s++) begin
         rst = ($urandom_range(0, 39) == 0);
         btn_go = $urandom_range(0, 1);
         btn_clr = ($urandom_range(0, 2) == 0);
         len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 14);
         if (rst) len = 1;
         for (int i = 0; i < len; i++) begin
            tick();
            tests_run++;
            if ({state, en, clr} !== {m_state, m_en, m_clr}) begin
               fails++;
               $display("FAIL random seg %0d: state=%b en=%b clr=%b, expected %b %b %b",
                        s, state, en, clr, m_state, m_en, m_clr);
            end
         end
      end
      rst = 1'b0;
      tests_run++;
      if (overlap !== 0) begin
         fails++;
         $display("FAIL clr_with_en: %0d cycles with clr and en both high, expected 0", overlap);
      end
   endtask

   initial begin
      test_reset();
      test_go_start();
      test_bounce();
      test_pause_clear();
      test_run_clr();
      test_paused_both();
      test_hold();
      test_rst_mid();
      test_hold_through_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
